ic_rgbtoycbcr_stream_converter: RTL

//  Parametrised RGB->YCbCr front end of the JPEG compression path. Converts a stream of RGB pixels
//  to level-shifted Y and signed Cb/Cr, packs ROW_PIX samples per channel into one row word, and

---
 rtl/ic_rgbtoycbcr_stream_converter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ic_rgbtoycbcr_stream_converter.sv
// ic_rgbtoycbcr_stream_converter: RGB pixel stream to packed Y/Cb/Cr row words for the JPEG BinDCT input.
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   mode       0 = chroma every row, 1 = chroma on even rows only
//   in_valid / in_ready / in_data   pixel input {B,G,R}, R in LSBs
//   out_valid / out_ready / out_data / out_chan   row word output, sample 0 in LSBs, chan 0=Y 1=Cb 2=Cr
//   Optional macro ROUND_EN: round half up before the fractional shift (default build truncates).
module ic_rgbtoycbcr_stream_converter #(
    parameter int PIX_W   = 8,
    parameter int ROW_PIX = 8,
    parameter int FRAC_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3*PIX_W-1:0]       in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ROW_PIX*PIX_W-1:0] out_data,
    output logic [1:0]               out_chan
);
    localparam int W  = PIX_W + FRAC_W + 3;
    localparam int CW = ROW_PIX > 1 ? $clog2(ROW_PIX) : 1;
    localparam int RW = ROW_PIX * PIX_W;
`ifdef ROUND_EN
    localparam logic signed [W-1:0] RND = W'(1 << (FRAC_W - 1));
`else
    localparam logic signed [W-1:0] RND = '0;
`endif
    localparam logic signed [W-1:0] HALF = W'(1 << (PIX_W - 1));
    localparam logic signed [W-1:0] MAXV = HALF - W'(1);
    localparam logic signed [W-1:0] MINV = -HALF;
    // Row-major: Y(R,G,B), Cb(R,G,B), Cr(R,G,B)
    localparam logic signed [W-1:0] COEF [9] = '{W'(19595), W'(38470), W'(7471),
                                                 W'(-11059), W'(-21709), W'(32768),
                                                 W'(32768), W'(-27439), W'(-5329)};

    typedef enum logic [1:0] {IDLE, EMIT_Y, EMIT_CB, EMIT_CR} state_t;

    state_t                state;
    logic                  s1_v, s2_v, hold_v, hold_chroma, odd_row, mode_l;
    logic [PIX_W-1:0]      s1_c [3];
    logic signed [W-1:0]   prod [9];
    logic [CW-1:0]         pix_cnt;
    logic [RW-1:0]         pack_y, pack_cb, pack_cr, hold_y, hold_cb, hold_cr, ny, ncb, ncr;
    logic                  row_done, last_hs, pipe_en, xfer;

    function automatic logic [PIX_W-1:0] sat(input logic signed [W-1:0] sum, input logic signed [W-1:0] off);
        logic signed [W-1:0] q;
        q = ((sum + RND) >>> FRAC_W) - off;
        return q > MAXV ? MAXV[PIX_W-1:0] : (q < MINV ? MINV[PIX_W-1:0] : q[PIX_W-1:0]);
    endfunction

    always_comb begin
        ny  = pack_y;
        ncb = pack_cb;
        ncr = pack_cr;
        ny [int'(pix_cnt)*PIX_W +: PIX_W] = sat(prod[0] + prod[1] + prod[2], HALF);
        ncb[int'(pix_cnt)*PIX_W +: PIX_W] = sat(prod[3] + prod[4] + prod[5], '0);
        ncr[int'(pix_cnt)*PIX_W +: PIX_W] = sat(prod[6] + prod[7] + prod[8], '0);
        row_done = s2_v && pix_cnt == CW'(ROW_PIX - 1);
        // The final beat of the held row frees the hold buffer in the same cycle it is refilled
        last_hs  = out_valid && out_ready && (state == EMIT_CR || (state == EMIT_Y && !hold_chroma));
        pipe_en  = !(row_done && hold_v && !last_hs);
        xfer     = pipe_en && row_done;
        in_ready = pipe_en;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            pix_cnt <= '0;
            pack_y  <= '0;
            pack_cb <= '0;
            pack_cr <= '0;
            for (int i = 0; i < 3; i++) s1_c[i] <= '0;
            for (int i = 0; i < 9; i++) prod[i] <= '0;
        end else if (pipe_en) begin
            s1_v <= in_valid;
            s2_v <= s1_v;
            for (int j = 0; j < 3; j++) s1_c[j] <= in_data[j*PIX_W +: PIX_W];
            for (int i = 0; i < 9; i++)
                prod[i] <= COEF[i] * $signed({{(W-PIX_W){1'b0}}, s1_c[i % 3]});
            if (s2_v) begin
                pack_y  <= ny;
                pack_cb <= ncb;
                pack_cr <= ncr;
                pix_cnt <= row_done ? '0 : pix_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            hold_v      <= 1'b0;
            hold_chroma <= 1'b0;
            odd_row     <= 1'b0;
            mode_l      <= 1'b0;
            hold_y      <= '0;
            hold_cb     <= '0;
            hold_cr     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_chan    <= 2'd0;
        end else begin
            if (xfer) begin
                hold_y      <= ny;
                hold_cb     <= ncb;
                hold_cr     <= ncr;
                hold_v      <= 1'b1;
                odd_row     <= !odd_row;
                // Even rows latch mode and always carry chroma; odd rows reuse the even row's mode
                mode_l      <= odd_row ? mode_l : mode;
                hold_chroma <= !odd_row || !mode_l;
            end else if (last_hs) begin
                hold_v <= 1'b0;
            end
            case (state)
                IDLE: if (hold_v) begin
                    state     <= EMIT_Y;
                    out_valid <= 1'b1;
                    out_data  <= hold_y;
                    out_chan  <= 2'd0;
                end
                EMIT_Y: if (out_ready) begin
                    state     <= hold_chroma ? EMIT_CB : IDLE;
                    out_valid <= hold_chroma;
                    out_data  <= hold_chroma ? hold_cb : out_data;
                    out_chan  <= hold_chroma ? 2'd1 : out_chan;
                end
                EMIT_CB: if (out_ready) begin
                    state    <= EMIT_CR;
                    out_data <= hold_cr;
                    out_chan <= 2'd2;
                end
                EMIT_CR: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
